// File: rtl/fifo_stream_drain.sv
// fifo_stream_drain: pops a sync-read FIFO and replays its words as a valid/ready stream.
// Optional pop counter pop_count_o is built only when FIFO_DRAIN_CNT_EN is defined.
module fifo_stream_drain #(
  parameter int DATA_WIDTH = 16,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  fifo_n_empty_i,
  output logic                  fifo_r_en_o,
  input  logic [DATA_WIDTH-1:0] fifo_data_i,
  input  logic                  flush_i,
  output logic                  v_o,
  output logic [DATA_WIDTH-1:0] data_o,
  input  logic                  ready_i
`ifdef FIFO_DRAIN_CNT_EN
  ,
  output logic [CNT_WIDTH-1:0]  pop_count_o
`endif
);
  logic [DATA_WIDTH-1:0] slots [2];
  logic                  head;
  logic                  tail;
  logic                  inflight;
  logic [1:0]            cnt;
  logic                  handoff;
  logic                  deq;
  logic                  enq;
  logic [2:0]            occ;

  assign v_o     = cnt != 2'd0;
  assign data_o  = slots[head];
  assign handoff = v_o & ready_i;
  assign deq     = handoff & ~flush_i;
  assign enq     = inflight & ~flush_i;
  // Credit counts the word still in flight, so a captured word always finds a free slot.
  assign occ         = {1'b0, cnt} + {2'b0, inflight} - {2'b0, handoff};
  assign fifo_r_en_o = reset_n & fifo_n_empty_i & ~flush_i & (occ < 3'd2);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt      <= 2'd0;
      inflight <= 1'b0;
      head     <= 1'b0;
      tail     <= 1'b0;
      slots[0] <= '0;
      slots[1] <= '0;
    end else begin
      inflight <= fifo_r_en_o;
      if (flush_i) begin
        cnt  <= 2'd0;
        head <= 1'b0;
        tail <= 1'b0;
      end else begin
        cnt <= cnt + {1'b0, enq} - {1'b0, deq};
        if (enq) begin
          slots[tail] <= fifo_data_i;
          tail        <= ~tail;
        end
        if (deq) head <= ~head;
      end
    end
  end

`ifdef FIFO_DRAIN_CNT_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) pop_count_o <= '0;
    else if (deq) pop_count_o <= pop_count_o + 1'b1;
  end
`endif

  a_cnt_bound: assert property (@(posedge clk) disable iff (!reset_n) cnt != 2'd3);
endmodule

// File: tb/tb_fifo_stream_drain.sv
// tb_fifo_stream_drain: directed scenarios against a behavioural sync-read FIFO model.
module tb_fifo_stream_drain;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        fifo_n_empty_i;
  logic        fifo_r_en_o;
  logic [15:0] fifo_data_i = '0;
  logic        flush_i = 1'b0;
  logic        v_o;
  logic [15:0] data_o;
  logic        ready_i = 1'b0;
  logic [15:0] mem [64];
  int          wr = 0;
  int          rd = 0;
  int          total = 0;
  int          bad = 0;

`ifdef FIFO_DRAIN_CNT_EN
  logic [3:0] pop_count_o;
  fifo_stream_drain #(.DATA_WIDTH(16), .CNT_WIDTH(4)) dut (
    .clk(clk), .reset_n(reset_n), .fifo_n_empty_i(fifo_n_empty_i), .fifo_r_en_o(fifo_r_en_o),
    .fifo_data_i(fifo_data_i), .flush_i(flush_i), .v_o(v_o), .data_o(data_o), .ready_i(ready_i),
    .pop_count_o(pop_count_o));
`else
  fifo_stream_drain #(.DATA_WIDTH(16)) dut (
    .clk(clk), .reset_n(reset_n), .fifo_n_empty_i(fifo_n_empty_i), .fifo_r_en_o(fifo_r_en_o),
    .fifo_data_i(fifo_data_i), .flush_i(flush_i), .v_o(v_o), .data_o(data_o), .ready_i(ready_i));
`endif

  always #5 clk = ~clk;

  assign fifo_n_empty_i = wr != rd;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd          <= 0;
      fifo_data_i <= '0;
    end else if (fifo_r_en_o) begin
      fifo_data_i <= mem[rd[5:0]];
      rd          <= rd + 1;
    end
  end

  task automatic load(input logic [15:0] w);
    mem[wr[5:0]] = w;
    wr++;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    wr      = 0;
    flush_i = 1'b0;
    ready_i = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    mem[0]  = 16'h1234;
    wr      = 1;
    ready_i = 1'b1;
    #1;
    total++; if (fifo_r_en_o !== 1'b0) begin bad++; $display("FAIL reset_r_en got=%b exp=0", fifo_r_en_o); end
    total++; if (v_o !== 1'b0) begin bad++; $display("FAIL reset_v got=%b exp=0", v_o); end
    total++; if (data_o !== 16'h0) begin bad++; $display("FAIL reset_data got=%h exp=0000", data_o); end
    do_reset();
  endtask

  task automatic test_basic();
    logic [6:0]  exp_r = 7'b0001111;
    logic [6:0]  exp_v = 7'b0111100;
    logic [15:0] w [4] = '{16'hA0A0, 16'hB1B1, 16'hC2C2, 16'hD3D3};
    do_reset();
    ready_i = 1'b1;
    for (int i = 0; i < 4; i++) load(w[i]);
    for (int k = 0; k < 7; k++) begin
      if (k > 0) @(negedge clk);
      #1;
      total++; if (fifo_r_en_o !== exp_r[k]) begin bad++; $display("FAIL basic_r_en c%0d got=%b exp=%b", k, fifo_r_en_o, exp_r[k]); end
      total++; if (v_o !== exp_v[k]) begin bad++; $display("FAIL basic_v c%0d got=%b exp=%b", k, v_o, exp_v[k]); end
      if (k >= 2 && k <= 5) begin
        total++; if (data_o !== w[k-2]) begin bad++; $display("FAIL basic_data c%0d got=%h exp=%h", k, data_o, w[k-2]); end
      end
    end
  endtask

  task automatic test_backpressure();
    logic [5:0] exp_r = 6'b000011;
    logic [5:0] exp_v = 6'b111100;
    ready_i = 1'b0;
    for (int i = 0; i < 6; i++) load(16'h0200 + 16'(i));
    for (int k = 0; k < 6; k++) begin
      if (k > 0) @(negedge clk);
      #1;
      total++; if (fifo_r_en_o !== exp_r[k]) begin bad++; $display("FAIL bp_r_en c%0d got=%b exp=%b", k, fifo_r_en_o, exp_r[k]); end
      total++; if (v_o !== exp_v[k]) begin bad++; $display("FAIL bp_v c%0d got=%b exp=%b", k, v_o, exp_v[k]); end
      if (k >= 2) begin
        total++; if (data_o !== 16'h0200) begin bad++; $display("FAIL bp_hold c%0d got=%h exp=0200", k, data_o); end
      end
    end
    for (int k = 6; k < 13; k++) begin
      @(negedge clk);
      ready_i = 1'b1;
      #1;
      if (k <= 8) begin
        total++; if (fifo_r_en_o !== 1'b1) begin bad++; $display("FAIL bp_resume c%0d got=%b exp=1", k, fifo_r_en_o); end
      end
      total++; if (v_o !== (k < 12)) begin bad++; $display("FAIL bp_drain_v c%0d got=%b exp=%b", k, v_o, k < 12); end
      if (k < 12) begin
        total++; if (data_o !== 16'h0200 + 16'(k - 6)) begin bad++; $display("FAIL bp_drain_data c%0d got=%h exp=%h", k, data_o, 16'h0200 + 16'(k - 6)); end
      end
    end
  endtask

  task automatic test_alternate();
    int got = 0;
    for (int i = 0; i < 16; i++) load(16'(i));
    for (int c = 0; c < 120 && got < 16; c++) begin
      @(negedge clk);
      ready_i = c[0] == 1'b0;
      #1;
      total++; if (dut.cnt > 2'd2) begin bad++; $display("FAIL alt_cnt c%0d got=%0d exp<=2", c, dut.cnt); end
      if (v_o && ready_i) begin
        total++; if (data_o !== 16'(got)) begin bad++; $display("FAIL alt_data got=%h exp=%h", data_o, 16'(got)); end
        got++;
      end
    end
    total++; if (got != 16) begin bad++; $display("FAIL alt_count got=%0d exp=16", got); end
    @(negedge clk);
    ready_i = 1'b0;
    #1;
    total++; if (v_o !== 1'b0) begin bad++; $display("FAIL alt_idle got=%b exp=0", v_o); end
  endtask

  task automatic test_flush();
    @(negedge clk);
    ready_i = 1'b0;
    load(16'h0C01);
    @(negedge clk);
    @(negedge clk);
    load(16'h0C02);
    load(16'h0C03);
    #1;
    total++; if (v_o !== 1'b1 || data_o !== 16'h0C01) begin bad++; $display("FAIL flush_pre got=%b/%h exp=1/0c01", v_o, data_o); end
    total++; if (fifo_r_en_o !== 1'b1) begin bad++; $display("FAIL flush_pre_r_en got=%b exp=1", fifo_r_en_o); end
    @(negedge clk);
    flush_i = 1'b1;
    ready_i = 1'b1;
    #1;
    total++; if (fifo_r_en_o !== 1'b0) begin bad++; $display("FAIL flush_r_en got=%b exp=0", fifo_r_en_o); end
    @(negedge clk);
    flush_i = 1'b0;
    ready_i = 1'b0;
    #1;
    total++; if (v_o !== 1'b0) begin bad++; $display("FAIL flush_v got=%b exp=0", v_o); end
    total++; if (fifo_r_en_o !== 1'b1) begin bad++; $display("FAIL flush_after_r_en got=%b exp=1", fifo_r_en_o); end
    @(negedge clk);
    #1;
    total++; if (v_o !== 1'b0) begin bad++; $display("FAIL flush_drop got=%b exp=0", v_o); end
    @(negedge clk);
    ready_i = 1'b1;
    #1;
    total++; if (v_o !== 1'b1 || data_o !== 16'h0C03) begin bad++; $display("FAIL flush_next got=%b/%h exp=1/0c03", v_o, data_o); end
    @(negedge clk);
    #1;
    total++; if (v_o !== 1'b0) begin bad++; $display("FAIL flush_end got=%b exp=0", v_o); end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    ready_i = 1'b0;
    for (int i = 0; i < 4; i++) load(16'h0E00 + 16'(i));
    repeat (3) @(negedge clk);
    #1;
    total++; if (v_o !== 1'b1 || data_o !== 16'h0E00 || fifo_r_en_o !== 1'b0) begin bad++; $display("FAIL mid_full got=%b/%h/%b exp=1/0e00/0", v_o, data_o, fifo_r_en_o); end
    reset_n = 1'b0;
    wr      = 4;
    #1;
    total++; if (v_o !== 1'b0) begin bad++; $display("FAIL mid_rst_v got=%b exp=0", v_o); end
    total++; if (data_o !== 16'h0) begin bad++; $display("FAIL mid_rst_data got=%h exp=0000", data_o); end
    total++; if (fifo_r_en_o !== 1'b0) begin bad++; $display("FAIL mid_rst_r_en got=%b exp=0", fifo_r_en_o); end
    @(negedge clk);
    test_basic();
  endtask

`ifdef FIFO_DRAIN_CNT_EN
  task automatic test_pop_count();
    do_reset();
    #1;
    total++; if (pop_count_o !== 4'd0) begin bad++; $display("FAIL cnt_reset got=%0d exp=0", pop_count_o); end
    ready_i = 1'b1;
    for (int i = 0; i < 17; i++) load(16'h0F00 + 16'(i));
    repeat (25) @(negedge clk);
    #1;
    total++; if (pop_count_o !== 4'd1) begin bad++; $display("FAIL cnt_wrap got=%0d exp=1", pop_count_o); end
    @(negedge clk);
    flush_i = 1'b1;
    @(negedge clk);
    flush_i = 1'b0;
    #1;
    total++; if (pop_count_o !== 4'd1) begin bad++; $display("FAIL cnt_flush got=%0d exp=1", pop_count_o); end
    reset_n = 1'b0;
    #1;
    total++; if (pop_count_o !== 4'd0) begin bad++; $display("FAIL cnt_rst got=%0d exp=0", pop_count_o); end
    do_reset();
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_alternate();
    test_flush();
    test_reset_mid();
`ifdef FIFO_DRAIN_CNT_EN
    test_pop_count();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end
endmodule
